// File: rtl/scm_tcdm_bridge_if.sv
// Two-master TCDM request/response bundle between masters and the register-file bridge.
// Each vector packs master p at slice p.
interface scm_tcdm_bridge_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
);
  logic [1:0]              req;
  logic [1:0]              we;
  logic [2*ADDR_WIDTH-1:0] add;
  logic [2*NUM_BYTE-1:0]   be;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic [1:0]              gnt;
  logic [1:0]              r_valid;
  logic [2*DATA_WIDTH-1:0] r_rdata;

  modport master (
    output req, we, add, be, wdata,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, we, add, be, wdata,
    output gnt, r_valid, r_rdata
  );
endinterface

// File: rtl/scm_tcdm_bridge.sv
// Round-robin two-master front-end onto the 1R1W byte-enable latch register file.
// Grants are combinational and responses follow one cycle later.
module scm_tcdm_bridge #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  scm_tcdm_bridge_if.slave      tcdm,
  output logic                  rf_read_enable_o,
  output logic [ADDR_WIDTH-1:0] rf_read_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_read_data_i,
  output logic                  rf_write_enable_o,
  output logic [ADDR_WIDTH-1:0] rf_write_addr_o,
  output logic [DATA_WIDTH-1:0] rf_write_data_o,
  output logic [NUM_BYTE-1:0]   rf_write_be_o,
  output logic [15:0]           conflict_cnt_o
);

  logic [1:0]            rd_req, wr_req;
  logic                  rd_any, wr_any;
  logic                  rd_sel, wr_sel;
  logic [1:0]            rd_gnt, wr_gnt, gnt;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [1:0]            rsp_vld_q, rsp_rd_q;
  logic [15:0]           cnt_q;

  always_comb begin
    rd_req = tcdm.req & ~tcdm.we;
    wr_req = tcdm.req & tcdm.we;
    rd_any = (|rd_req) & ~rst;
    wr_any = (|wr_req) & ~rst;
    rd_sel = (rd_req == 2'b11) ? rd_ptr_q : rd_req[1];
    wr_sel = (wr_req == 2'b11) ? wr_ptr_q : wr_req[1];
    rd_gnt = rd_any ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
    wr_gnt = wr_any ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
    gnt    = rd_gnt | wr_gnt;
  end

  assign tcdm.gnt = gnt;

  // Read address holds its last value when idle so the RF address latch never glitches.
  assign rf_read_enable_o = rd_any;
  assign rf_read_addr_o   = !rd_any ? rd_addr_q :
                            rd_sel  ? tcdm.add[ADDR_WIDTH +: ADDR_WIDTH] :
                                      tcdm.add[0 +: ADDR_WIDTH];

  assign rf_write_enable_o = wr_any;
  assign rf_write_addr_o   = wr_sel ? tcdm.add[ADDR_WIDTH +: ADDR_WIDTH]
                                    : tcdm.add[0 +: ADDR_WIDTH];
  assign rf_write_data_o   = wr_sel ? tcdm.wdata[DATA_WIDTH +: DATA_WIDTH]
                                    : tcdm.wdata[0 +: DATA_WIDTH];
  assign rf_write_be_o     = !wr_any ? '0 :
                             wr_sel  ? tcdm.be[NUM_BYTE +: NUM_BYTE] :
                                       tcdm.be[0 +: NUM_BYTE];

  assign tcdm.r_valid = rsp_vld_q;
  assign tcdm.r_rdata[0 +: DATA_WIDTH]          = rsp_rd_q[0] ? rf_read_data_i : '0;
  assign tcdm.r_rdata[DATA_WIDTH +: DATA_WIDTH] = rsp_rd_q[1] ? rf_read_data_i : '0;
  assign conflict_cnt_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_addr_q <= '0;
      rsp_vld_q <= 2'b00;
      rsp_rd_q  <= 2'b00;
      cnt_q     <= 16'd0;
    end else begin
      if (rd_req == 2'b11) rd_ptr_q <= ~rd_sel;
      if (wr_req == 2'b11) wr_ptr_q <= ~wr_sel;
      rd_addr_q <= rf_read_addr_o;
      rsp_vld_q <= gnt;
      rsp_rd_q  <= gnt & ~tcdm.we;
      if ((|(tcdm.req & ~gnt)) && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_scm_tcdm_bridge.sv
// Scoreboard bench for scm_tcdm_bridge with a write-first 1R1W register-file stub.
module tb_scm_tcdm_bridge;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scm_tcdm_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) tcdm ();

  logic          rf_re, rf_we;
  logic [AW-1:0] rf_ra, rf_wa;
  logic [DW-1:0] rf_wd, rf_rd;
  logic [NB-1:0] rf_be;
  logic [15:0]   cnt;

  scm_tcdm_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .tcdm              (tcdm.slave),
    .rf_read_enable_o  (rf_re),
    .rf_read_addr_o    (rf_ra),
    .rf_read_data_i    (rf_rd),
    .rf_write_enable_o (rf_we),
    .rf_write_addr_o   (rf_wa),
    .rf_write_data_o   (rf_wd),
    .rf_write_be_o     (rf_be),
    .conflict_cnt_o    (cnt)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Register-file stub: write-first, read data valid the cycle after ReadEnable.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_wa] <= merge(rf_mem[rf_wa], rf_wd, rf_be);
    if (rf_re) rf_rd <= (rf_we && rf_wa == rf_ra) ? merge(rf_mem[rf_ra], rf_wd, rf_be)
                                                  : rf_mem[rf_ra];
  end

  logic [31:0] gmem [32];
  logic        m_rdp, m_wrp;
  logic [15:0] m_cnt;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic [1:0] req, input logic [1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [NB-1:0] b0, input logic [NB-1:0] b1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      output logic [1:0] g);
    logic [1:0] rd, wr, ge;
    logic rs, ws;
    logic [31:0] e;
    tcdm.req = req; tcdm.we = we; tcdm.add = {a1, a0};
    tcdm.be = {b1, b0}; tcdm.wdata = {d1, d0};
    @(negedge clk);
    chk("rvalid0", 32'(tcdm.r_valid[0]), 32'(q0.size() > 0));
    if (q0.size() > 0) begin e = q0.pop_front(); chk("rdata0", tcdm.r_rdata[31:0], e); end
    chk("rvalid1", 32'(tcdm.r_valid[1]), 32'(q1.size() > 0));
    if (q1.size() > 0) begin e = q1.pop_front(); chk("rdata1", tcdm.r_rdata[63:32], e); end
    chk("cnt", 32'(cnt), 32'(m_cnt));
    rd = req & ~we;
    wr = req & we;
    rs = (rd == 2'b11) ? m_rdp : rd[1];
    ws = (wr == 2'b11) ? m_wrp : wr[1];
    ge = 2'b00;
    if (|rd) ge[rs] = 1'b1;
    if (|wr) ge[ws] = 1'b1;
    chk("gnt", 32'(tcdm.gnt), 32'(ge));
    chk("rf_re", 32'(rf_re), 32'(|rd));
    chk("rf_we", 32'(rf_we), 32'(|wr));
    if (|wr) begin
      chk("rf_wa", 32'(rf_wa), 32'(ws ? a1 : a0));
      gmem[ws ? a1 : a0] = merge(gmem[ws ? a1 : a0], ws ? d1 : d0, ws ? b1 : b0);
    end else chk("rf_be_idle", 32'(rf_be), 32'd0);
    if (|rd) chk("rf_ra", 32'(rf_ra), 32'(rs ? a1 : a0));
    if (ge[0]) q0.push_back(we[0] ? 32'd0 : gmem[a0]);
    if (ge[1]) q1.push_back(we[1] ? 32'd0 : gmem[a1]);
    if (rd == 2'b11) m_rdp = ~m_rdp;
    if (wr == 2'b11) m_wrp = ~m_wrp;
    if ((|(req & ~ge)) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    g = ge;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    logic [1:0] g;
    step(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, g);
  endtask

  // Denied masters keep their request unchanged until granted.
  task automatic issue(input logic [1:0] req, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [NB-1:0] b0, input logic [NB-1:0] b1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [1:0] pend, g;
    pend = req;
    for (int i = 0; i < 4 && pend != 2'b00; i++) begin
      step(pend, we, a0, a1, b0, b1, d0, d1, g);
      pend = pend & ~g;
    end
    chk("hold_bound", 32'(pend), 32'd0);
  endtask

  initial begin
    logic [1:0] g;
    rst = 1'b1;
    tcdm.req = 2'b11; tcdm.we = 2'b00; tcdm.add = '0; tcdm.be = '0; tcdm.wdata = '0;
    m_rdp = 1'b0; m_wrp = 1'b0; m_cnt = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(tcdm.gnt), 32'd0);
    chk("rst_rvalid", 32'(tcdm.r_valid), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_rf_re", 32'(rf_re), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int a = 0; a < 32; a++)
      step(2'b10, 2'b10, '0, AW'(a), '0, 4'hF, '0, {8'(a), 8'hA5, 8'(a ^ 5), 8'h3C}, g);
    idle();

    step(2'b11, 2'b00, 5'd3, 5'd7, '0, '0, '0, '0, g);
    chk("first_contest", 32'(g), 32'd1);
    repeat (3) step(2'b11, 2'b00, 5'd3, 5'd7, '0, '0, '0, '0, g);
    chk("cnt4", 32'(cnt), 32'd4);
    idle();

    step(2'b11, 2'b01, 5'd5, 5'd5, 4'hF, '0, 32'hA5A5_1234, '0, g);
    idle();

    step(2'b01, 2'b01, 5'd9, '0, 4'hF, '0, 32'h0, '0, g);
    step(2'b01, 2'b01, 5'd9, '0, 4'b0101, '0, 32'hFFFF_FFFF, '0, g);
    step(2'b01, 2'b00, 5'd9, '0, '0, '0, '0, '0, g);
    step(2'b10, 2'b10, '0, 5'd9, '0, 4'h0, '0, 32'hDEAD_BEEF, g);
    step(2'b10, 2'b00, '0, 5'd9, '0, '0, '0, '0, g);
    idle();

    issue(2'b11, 2'b11, 5'd12, 5'd12, 4'hF, 4'hF, 32'd1, 32'd2);
    step(2'b01, 2'b00, 5'd12, '0, '0, '0, '0, '0, g);
    issue(2'b11, 2'b11, 5'd12, 5'd12, 4'hF, 4'hF, 32'd3, 32'd4);
    step(2'b10, 2'b00, '0, 5'd12, '0, '0, '0, '0, g);
    idle();

    tcdm.req = 2'b11; tcdm.we = 2'b00; tcdm.add = {5'd7, 5'd3};
    repeat (65600) @(posedge clk);
    #1;
    chk("cnt_sat", 32'(cnt), 32'h0000_FFFF);
    chk("rv_busy", 32'(|tcdm.r_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_rv", 32'(tcdm.r_valid), 32'd0);
    chk("rst_drop_cnt", 32'(cnt), 32'd0);
    chk("rst_hold_gnt", 32'(tcdm.gnt), 32'd0);
    q0.delete(); q1.delete();
    m_rdp = 1'b0; m_wrp = 1'b0; m_cnt = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(2'b11, 2'b00, 5'd3, 5'd7, '0, '0, '0, '0, g);
    chk("post_rst_contest", 32'(g), 32'd1);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/scm_tcdm_bridge.md
# scm_tcdm_bridge

Two-port TCDM-style front-end for the latch-based 1R1W byte-enable register file. Accepts read/write requests from two masters, such as a core data port and a DMA port, and arbitrates them round-robin onto the register file's single read port and single write port. It returns responses with fixed one-cycle latency. It sits directly upstream of the register file and drives all of its read/write ports.

## Interface
Parameters:
- ADDR_WIDTH, 5, word address width; must match the register file.
- DATA_WIDTH, 32, data width; multiple of 8.
- NUM_BYTE, DATA_WIDTH/8, byte lanes per word.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_i  in  2  request valid, bit p = master p.
- we_i  in  2  1 = write, 0 = read, per master.
- add_i  in  2*ADDR_WIDTH  word address; slice p = [p*ADDR_WIDTH +: ADDR_WIDTH].
- be_i  in  2*NUM_BYTE  byte enables, per master.
- wdata_i  in  2*DATA_WIDTH  write data, per master.
- gnt_o  out  2  grant, combinational, same cycle as request.
- r_valid_o  out  2  response valid, per master.
- r_rdata_o  out  2*DATA_WIDTH  read data, per master.
- rf_read_enable_o  out  1  to register file ReadEnable.
- rf_read_addr_o  out  ADDR_WIDTH  to ReadAddr.
- rf_read_data_i  in  DATA_WIDTH  from ReadData; valid the cycle after the read grant.
- rf_write_enable_o  out  1  to WriteEnable.
- rf_write_addr_o  out  ADDR_WIDTH  to WriteAddr.
- rf_write_data_o  out  DATA_WIDTH  to WriteData.
- rf_write_be_o  out  NUM_BYTE  to WriteBE.
- conflict_cnt_o  out  16  saturating count of denied request-cycles.

## Operation
- Request classes: read = req&!we; write = req&we. Each master issues one operation per cycle.
- Read arbiter:
  - One read requester: grant it.
  - Two read requesters: grant the master indicated by rd_ptr; rd_ptr <= the other master.
  - rd_ptr changes only on contested cycles.
- Write arbiter: identical, with its own wr_ptr.
- Mixed cycle (one read, one write): both granted, no pointer update.
- Granted read: rf_read_enable_o=1, rf_read_addr_o = that master's address.
- Granted write: rf_write_enable_o=1, and addr/data/be are muxed from the winner.
  - be=0 is still granted and asserts the enable. The register file makes no change.
- No granted read: rf_read_enable_o=0; address output holds the last value, so there are no glitches on the RF address register.
- No granted write: rf_write_enable_o=0 and rf_write_be_o=0.
- Response tracking: registered rsp_vld[p] <= gnt_o[p]; rsp_rd[p] <= gnt_o[p] & !we_i[p].
- r_valid_o[p] = rsp_vld[p].
- r_rdata_o[p] = rsp_rd[p] ? rf_read_data_i : 0. Write responses carry zero data.
- Same-cycle read and write to the same address are write-first: the read response returns the newly written bytes in enabled lanes and old bytes elsewhere. The bridge does no forwarding; this is the register file's native behaviour and must be preserved.
- Denied masters must hold req/we/add/be/wdata stable until granted. The bridge does not buffer requests.
- conflict_cnt_o increments by 1 in each cycle where any req_i bit is high with gnt_o low, and saturates at 16'hFFFF.

## Timing
- Grant: combinational, zero cycles.
- Response: exactly 1 cycle after grant, for reads and writes.
- Throughput: 1 read plus 1 write per cycle.
- Reset values: rd_ptr=0, wr_ptr=0, rsp_vld=0, rsp_rd=0, conflict_cnt_o=0, rf_read_addr_o=0.
  - Therefore r_valid_o=0, r_rdata_o=0.
  - gnt_o and rf_* enables follow the combinational rules: 0 when req_i=0.
- Reset asserted mid-operation: in-flight responses are dropped (r_valid_o=0 immediately, asynchronously) and pointers return to 0.
- Outputs while rst is high: gnt_o and rf_* enables are forced to 0.

## Test plan
- Reset: assert rst with req_i=2'b11 -> gnt_o=0, r_valid_o=0, conflict_cnt_o=0. Release -> both masters' first contested read grants master 0.
- Contested reads: both masters read (addr 3, addr 7) for 4 cycles -> grants alternate 0,1,0,1; each r_valid_o the following cycle returns mem[3]/mem[7]; conflict_cnt_o=4.
- Mixed: master 0 writes 32'hA5A5_1234, be=4'hF, addr 5, while master 1 reads addr 5 in the same cycle -> both granted; next cycle r_rdata_o[1]=32'hA5A5_1234 (write-first), r_valid_o=2'b11, r_rdata_o[0]=0.
- Partial write: write 32'hFFFF_FFFF be=4'b0101 to a word holding 0 -> a read returns 32'h00FF_00FF. A write with be=0 -> granted, r_valid next cycle, content unchanged.
- Contested writes to the same address, master 0 data 1 and master 1 data 2, held until granted -> final content 2, each master gets exactly one r_valid.
- Counter saturation: force 70000 contested cycles -> conflict_cnt_o=16'hFFFF. Reset mid-burst with a read outstanding -> r_valid_o drops the same cycle, counter=0.
